// File: rtl/mem_wb_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_wb_pkg : shared types and default widths for the MEM/WB stage
// Rev 1.0
// ---------------------------------------------------------------------------
package mem_wb_pkg;

  localparam int DEF_DATA_W    = 32;
  localparam int DEF_NUM_LANES = 2;
  localparam int DEF_REG_W     = 5;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } skid_state_e;

  // Entry layout at the default widths; the stage builds the same layout
  // from its own parameters, so field order here is the reference.
  typedef struct packed {
    logic [DEF_NUM_LANES*DEF_DATA_W-1:0] data;
    logic                                reg_wen;
    logic                                dmem_alu;
    logic                                jr;
    logic [DEF_REG_W-1:0]                regd;
  } mem_wb_entry_t;

  function automatic int entry_width(input int data_w, input int lanes, input int reg_w);
    return lanes * data_w + 3 + reg_w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_wb_stage_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_wb_stage_if : valid/ready entry bus between pipeline stages
// Rev 1.0
// ---------------------------------------------------------------------------
interface mem_wb_stage_if
  import mem_wb_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int NUM_LANES = DEF_NUM_LANES,
  parameter int REG_W     = DEF_REG_W
);

  logic                        valid;
  logic                        ready;
  logic [NUM_LANES*DATA_W-1:0] data;
  logic                        reg_wen;
  logic                        dmem_alu;
  logic                        jr;
  logic [REG_W-1:0]            regd;

  modport master (
    output valid, data, reg_wen, dmem_alu, jr, regd,
    input  ready
  );

  modport slave (
    input  valid, data, reg_wen, dmem_alu, jr, regd,
    output ready
  );

endinterface
`default_nettype wire

// File: rtl/pipe_skid_buf.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pipe_skid_buf : payload-agnostic two-entry skid buffer (or single register)
// Rev 1.0
// ---------------------------------------------------------------------------
module pipe_skid_buf
  import mem_wb_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SKID  = 1
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic             flush_i,
  input  wire logic             in_valid_i,
  output logic                  in_ready_o,
  input  wire logic [WIDTH-1:0] in_data_i,
  output logic                  out_valid_o,
  input  wire logic             out_ready_i,
  output logic [WIDTH-1:0]      out_data_o,
  output logic [1:0]            occupancy_o
);

  generate
    if (SKID != 0) begin : g_skid
      skid_state_e      state_q, state_d;
      logic [WIDTH-1:0] main_q, main_d;
      logic [WIDTH-1:0] skid_q, skid_d;
      logic             in_fire;
      logic             out_fire;

      // Ready depends only on the state register, never on out_ready_i.
      assign in_ready_o  = (state_q != TWO);
      assign out_valid_o = (state_q != EMPTY);
      assign out_data_o  = main_q;
      assign in_fire     = in_valid_i & in_ready_o;
      assign out_fire    = out_valid_o & out_ready_i;
      assign occupancy_o = (state_q == TWO) ? 2'd2 :
                           (state_q == ONE) ? 2'd1 : 2'd0;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          state_q <= EMPTY;
          main_q  <= '0;
          skid_q  <= '0;
        end else begin
          state_q <= state_d;
          main_q  <= main_d;
          skid_q  <= skid_d;
        end
      end

      always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
          EMPTY: begin
            if (in_fire) begin
              state_d = ONE;
              main_d  = in_data_i;
            end
          end
          ONE: begin
            if (in_fire && !out_fire) begin
              state_d = TWO;
              skid_d  = in_data_i;
            end else if (in_fire && out_fire) begin
              main_d  = in_data_i;
            end else if (out_fire) begin
              state_d = EMPTY;
            end
          end
          TWO: begin
            if (out_fire) begin
              state_d = ONE;
              main_d  = skid_q;
            end
          end
          default: state_d = EMPTY;
        endcase
        // Flush only drops validity; stored payloads are left untouched.
        if (flush_i) begin
          state_d = EMPTY;
          main_d  = main_q;
          skid_d  = skid_q;
        end
      end
    end else begin : g_reg
      logic             valid_q, valid_d;
      logic [WIDTH-1:0] main_q, main_d;
      logic             in_fire;
      logic             out_fire;

      assign in_ready_o  = out_ready_i | ~valid_q;
      assign out_valid_o = valid_q;
      assign out_data_o  = main_q;
      assign in_fire     = in_valid_i & in_ready_o;
      assign out_fire    = valid_q & out_ready_i;
      assign occupancy_o = {1'b0, valid_q};

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          valid_q <= 1'b0;
          main_q  <= '0;
        end else begin
          valid_q <= valid_d;
          main_q  <= main_d;
        end
      end

      always_comb begin
        valid_d = valid_q;
        main_d  = main_q;
        if (flush_i) begin
          valid_d = 1'b0;
        end else if (in_fire) begin
          valid_d = 1'b1;
          main_d  = in_data_i;
        end else if (out_fire) begin
          valid_d = 1'b0;
        end
      end
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/mem_wb_stage.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_wb_stage : MEM/WB stage with skid buffer, flush and write-back select
// Rev 1.0
// ---------------------------------------------------------------------------
module mem_wb_stage
  import mem_wb_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int NUM_LANES = DEF_NUM_LANES,
  parameter int REG_W     = DEF_REG_W,
  parameter int SKID      = 1
) (
  input  wire logic           clk,
  input  wire logic           rst_n,
  input  wire logic           flush_i,
  mem_wb_stage_if.slave       in_if,
  mem_wb_stage_if.master      out_if,
  output logic [DATA_W-1:0]   wb_data_o,
  output logic [1:0]          occupancy_o
);

  localparam int ENTRY_W = entry_width(DATA_W, NUM_LANES, REG_W);

  typedef struct packed {
    logic [NUM_LANES*DATA_W-1:0] data;
    logic                        reg_wen;
    logic                        dmem_alu;
    logic                        jr;
    logic [REG_W-1:0]            regd;
  } entry_t;

  entry_t in_entry;
  entry_t head;
  logic   head_valid;

  assign in_entry.data     = in_if.data;
  assign in_entry.reg_wen  = in_if.reg_wen;
  assign in_entry.dmem_alu = in_if.dmem_alu;
  assign in_entry.jr       = in_if.jr;
  assign in_entry.regd     = in_if.regd;

  pipe_skid_buf #(
    .WIDTH (ENTRY_W),
    .SKID  (SKID)
  ) u_buf (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (flush_i),
    .in_valid_i  (in_if.valid),
    .in_ready_o  (in_if.ready),
    .in_data_i   (in_entry),
    .out_valid_o (head_valid),
    .out_ready_i (out_if.ready),
    .out_data_o  (head),
    .occupancy_o (occupancy_o)
  );

  assign out_if.valid    = head_valid;
  assign out_if.data     = head.data;
  // A bubble must never write the register file.
  assign out_if.reg_wen  = head.reg_wen & head_valid;
  assign out_if.dmem_alu = head.dmem_alu;
  assign out_if.jr       = head.jr;
  assign out_if.regd     = head.regd;

  generate
    if (NUM_LANES == 1) begin : g_wb_single
      assign wb_data_o = head.data[DATA_W-1:0];
    end else begin : g_wb_mux
      assign wb_data_o = head.dmem_alu ? head.data[DATA_W +: DATA_W]
                                       : head.data[DATA_W-1:0];
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_mem_wb_stage.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mem_wb_stage : self-checking bench for both SKID builds of mem_wb_stage
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_mem_wb_stage;
  import mem_wb_pkg::*;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          out_ready;
  logic          flush;
  mem_wb_entry_t cur;

  logic [31:0]   wb1, wb0;
  logic [1:0]    occ1, occ0;

  int total;
  int bad;

  mem_wb_entry_t q1[$];
  mem_wb_entry_t q0[$];

  mem_wb_stage_if #(.DATA_W(32), .NUM_LANES(2), .REG_W(5)) in_if1 ();
  mem_wb_stage_if #(.DATA_W(32), .NUM_LANES(2), .REG_W(5)) out_if1 ();
  mem_wb_stage_if #(.DATA_W(32), .NUM_LANES(2), .REG_W(5)) in_if0 ();
  mem_wb_stage_if #(.DATA_W(32), .NUM_LANES(2), .REG_W(5)) out_if0 ();

  assign in_if1.valid    = in_valid;
  assign in_if1.data     = cur.data;
  assign in_if1.reg_wen  = cur.reg_wen;
  assign in_if1.dmem_alu = cur.dmem_alu;
  assign in_if1.jr       = cur.jr;
  assign in_if1.regd     = cur.regd;
  assign out_if1.ready   = out_ready;

  assign in_if0.valid    = in_valid;
  assign in_if0.data     = cur.data;
  assign in_if0.reg_wen  = cur.reg_wen;
  assign in_if0.dmem_alu = cur.dmem_alu;
  assign in_if0.jr       = cur.jr;
  assign in_if0.regd     = cur.regd;
  assign out_if0.ready   = out_ready;

  mem_wb_stage #(.DATA_W(32), .NUM_LANES(2), .REG_W(5), .SKID(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .flush_i(flush),
    .in_if(in_if1), .out_if(out_if1), .wb_data_o(wb1), .occupancy_o(occ1)
  );

  mem_wb_stage #(.DATA_W(32), .NUM_LANES(2), .REG_W(5), .SKID(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .flush_i(flush),
    .in_if(in_if0), .out_if(out_if0), .wb_data_o(wb0), .occupancy_o(occ0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic mem_wb_entry_t mk(input logic [4:0] rd, input logic [31:0] l0,
                                       input logic [31:0] l1, input logic wen, input logic dm);
    mem_wb_entry_t e;
    e.data     = {l1, l0};
    e.reg_wen  = wen;
    e.dmem_alu = dm;
    e.jr       = 1'b0;
    e.regd     = rd;
    return e;
  endfunction

  function automatic logic [31:0] exp_wb(input mem_wb_entry_t e);
    return e.dmem_alu ? e.data[63:32] : e.data[31:0];
  endfunction

  // Reference: a FIFO of capacity 2 (skid) or 1 (plain register).
  task automatic step();
    bit f1_in, f1_out, f0_in, f0_out;
    f1_in  = in_valid && (q1.size() < 2);
    f1_out = out_ready && (q1.size() > 0);
    f0_in  = in_valid && (out_ready || (q0.size() == 0));
    f0_out = out_ready && (q0.size() > 0);
    @(posedge clk);
    if (flush) begin
      q1.delete();
      q0.delete();
    end else begin
      if (f1_out) void'(q1.pop_front());
      if (f1_in)  q1.push_back(cur);
      if (f0_out) void'(q0.pop_front());
      if (f0_in)  q0.push_back(cur);
    end
    #1;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    repeat (3) step();
  endtask

  task automatic test_reset();
    #3;
    total++; if (out_if1.valid !== 1'b0) begin bad++; $display("FAIL reset_valid1 got=%b exp=0", out_if1.valid); end
    total++; if (in_if1.ready !== 1'b1) begin bad++; $display("FAIL reset_ready1 got=%b exp=1", in_if1.ready); end
    total++; if (occ1 !== 2'd0) begin bad++; $display("FAIL reset_occ1 got=%0d exp=0", occ1); end
    total++; if (wb1 !== 32'd0) begin bad++; $display("FAIL reset_wb1 got=%h exp=0", wb1); end
    total++; if (out_if1.reg_wen !== 1'b0) begin bad++; $display("FAIL reset_wen1 got=%b exp=0", out_if1.reg_wen); end
    total++; if (out_if0.valid !== 1'b0 || occ0 !== 2'd0 || wb0 !== 32'd0) begin
      bad++; $display("FAIL reset_dut0 valid=%b occ=%0d wb=%h exp=0/0/0", out_if0.valid, occ0, wb0);
    end
    #3 rst_n = 1'b1;
    step();
    total++; if (out_if1.valid !== 1'b0) begin bad++; $display("FAIL reset_idle_valid got=%b exp=0", out_if1.valid); end
  endtask

  task automatic test_stream();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cur      = mk(5'(i + 1), 32'(32'h10 + i), 32'h0, 1'b1, 1'b0);
      in_valid = 1'b1;
      #1;
      total++; if (in_if1.ready !== 1'b1) begin bad++; $display("FAIL stream_ready[%0d] got=%b exp=1", i, in_if1.ready); end
      step();
      total++; if (out_if1.valid !== 1'b1 || out_if1.regd !== 5'(i + 1)) begin
        bad++; $display("FAIL stream_head[%0d] valid=%b regd=%0d exp=1/%0d", i, out_if1.valid, out_if1.regd, i + 1);
      end
      total++; if (wb1 !== 32'(32'h10 + i)) begin bad++; $display("FAIL stream_wb[%0d] got=%h exp=%h", i, wb1, 32'h10 + i); end
    end
    in_valid = 1'b0;
    #1;
    step();
    total++; if (out_if1.valid !== 1'b0) begin bad++; $display("FAIL stream_end_valid got=%b exp=0", out_if1.valid); end
  endtask

  task automatic test_backpressure();
    mem_wb_entry_t exp[$];
    logic [4:0]    got[$];
    int            idx;
    bit            acc;
    idx = 0;
    exp = '{mk(5'd21, 32'hA0, 32'h1, 1'b1, 1'b0), mk(5'd22, 32'hB0, 32'h2, 1'b1, 1'b1),
            mk(5'd23, 32'hC0, 32'h3, 1'b0, 1'b0)};
    for (int cyc = 0; cyc < 16 && got.size() < 3; cyc++) begin
      out_ready = (cyc >= 4);
      in_valid  = (idx < 3);
      if (idx < 3) cur = exp[idx];
      #1;
      if (cyc == 2) begin
        total++; if (occ1 !== 2'd2) begin bad++; $display("FAIL bp_occ got=%0d exp=2", occ1); end
        total++; if (in_if1.ready !== 1'b0) begin bad++; $display("FAIL bp_ready got=%b exp=0", in_if1.ready); end
        total++; if (out_if1.regd !== 5'd21) begin bad++; $display("FAIL bp_head got=%0d exp=21", out_if1.regd); end
      end
      if (cyc == 3) begin
        total++; if (idx !== 2 || occ1 !== 2'd2) begin bad++; $display("FAIL bp_hold idx=%0d occ=%0d exp=2/2", idx, occ1); end
      end
      acc = in_valid && in_if1.ready;
      if (out_if1.valid && out_ready) got.push_back(out_if1.regd);
      step();
      if (acc) idx++;
    end
    total++; if (got.size() != 3) begin bad++; $display("FAIL bp_count got=%0d exp=3", got.size()); end
    for (int k = 0; k < got.size() && k < 3; k++) begin
      total++; if (got[k] !== exp[k].regd) begin bad++; $display("FAIL bp_order[%0d] got=%0d exp=%0d", k, got[k], exp[k].regd); end
    end
  endtask

  task automatic test_skid0();
    mem_wb_entry_t exp[$];
    logic [4:0]    got[$];
    int            idx;
    bit            acc;
    idx = 0;
    exp = '{mk(5'd11, 32'h11, 32'h0, 1'b1, 1'b0), mk(5'd12, 32'h12, 32'h0, 1'b1, 1'b0),
            mk(5'd13, 32'h13, 32'h0, 1'b1, 1'b0)};
    for (int cyc = 0; cyc < 16 && got.size() < 3; cyc++) begin
      out_ready = (cyc >= 4);
      in_valid  = (idx < 3);
      if (idx < 3) cur = exp[idx];
      #1;
      total++; if (in_if0.ready !== (out_ready || (q0.size() == 0))) begin
        bad++; $display("FAIL s0_ready[%0d] got=%b exp=%b", cyc, in_if0.ready, out_ready || (q0.size() == 0));
      end
      total++; if (occ0 > 2'd1) begin bad++; $display("FAIL s0_occ[%0d] got=%0d exp<=1", cyc, occ0); end
      acc = in_valid && in_if0.ready;
      if (out_if0.valid && out_ready) got.push_back(out_if0.regd);
      step();
      if (acc) idx++;
    end
    total++; if (got.size() != 3) begin bad++; $display("FAIL s0_count got=%0d exp=3", got.size()); end
    for (int k = 0; k < got.size() && k < 3; k++) begin
      total++; if (got[k] !== exp[k].regd) begin bad++; $display("FAIL s0_order[%0d] got=%0d exp=%0d", k, got[k], exp[k].regd); end
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    cur = mk(5'd1, 32'h100, 32'h0, 1'b1, 1'b0); #1; step();
    cur = mk(5'd2, 32'h200, 32'h0, 1'b1, 1'b0); #1; step();
    total++; if (occ1 !== 2'd2) begin bad++; $display("FAIL flush_fill got=%0d exp=2", occ1); end
    flush = 1'b1;
    cur   = mk(5'd3, 32'h300, 32'h0, 1'b1, 1'b0);
    #1; step();
    flush    = 1'b0;
    in_valid = 1'b0;
    #1;
    total++; if (out_if1.valid !== 1'b0 || occ1 !== 2'd0 || in_if1.ready !== 1'b1) begin
      bad++; $display("FAIL flush_state valid=%b occ=%0d ready=%b exp=0/0/1", out_if1.valid, occ1, in_if1.ready);
    end
    total++; if (out_if0.valid !== 1'b0) begin bad++; $display("FAIL flush_dut0 got=%b exp=0", out_if0.valid); end
    out_ready = 1'b1;
    step();
    total++; if (out_if1.valid !== 1'b0) begin bad++; $display("FAIL flush_discard got=%b exp=0", out_if1.valid); end
  endtask

  task automatic test_select();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    cur = mk(5'd7, 32'hAAAA, 32'h5555, 1'b1, 1'b1);
    #1; step();
    in_valid = 1'b0;
    #1;
    total++; if (wb1 !== 32'h5555) begin bad++; $display("FAIL sel_wb1 got=%h exp=00005555", wb1); end
    total++; if (wb0 !== 32'h5555) begin bad++; $display("FAIL sel_wb0 got=%h exp=00005555", wb0); end
    total++; if (out_if1.reg_wen !== 1'b1) begin bad++; $display("FAIL sel_wen got=%b exp=1", out_if1.reg_wen); end
    out_ready = 1'b1;
    #1; step();
    total++; if (out_if1.valid !== 1'b0 || out_if1.reg_wen !== 1'b0) begin
      bad++; $display("FAIL sel_bubble valid=%b wen=%b exp=0/0", out_if1.valid, out_if1.reg_wen);
    end
    total++; if (out_if0.reg_wen !== 1'b0) begin bad++; $display("FAIL sel_bubble0 got=%b exp=0", out_if0.reg_wen); end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    cur = mk(5'd9,  32'h900, 32'h990, 1'b1, 1'b0); #1; step();
    cur = mk(5'd10, 32'hA00, 32'hAA0, 1'b1, 1'b1); #1; step();
    in_valid = 1'b0;
    #1;
    total++; if (occ1 !== 2'd2) begin bad++; $display("FAIL arst_fill got=%0d exp=2", occ1); end
    #1 rst_n = 1'b0;
    #1;
    total++; if (out_if1.valid !== 1'b0 || out_if1.reg_wen !== 1'b0 || occ1 !== 2'd0) begin
      bad++; $display("FAIL arst_state valid=%b wen=%b occ=%0d exp=0/0/0", out_if1.valid, out_if1.reg_wen, occ1);
    end
    total++; if (wb1 !== 32'd0 || out_if1.data !== 64'd0 || out_if1.regd !== 5'd0) begin
      bad++; $display("FAIL arst_data wb=%h data=%h regd=%0d exp=0", wb1, out_if1.data, out_if1.regd);
    end
    total++; if (in_if1.ready !== 1'b1) begin bad++; $display("FAIL arst_ready got=%b exp=1", in_if1.ready); end
    total++; if (out_if0.valid !== 1'b0 || occ0 !== 2'd0) begin
      bad++; $display("FAIL arst_dut0 valid=%b occ=%0d exp=0/0", out_if0.valid, occ0);
    end
    q1.delete();
    q0.delete();
    #2 rst_n = 1'b1;
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 1) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      cur       = mk(5'($urandom), $urandom, $urandom, 1'($urandom), 1'($urandom));
      cur.jr    = 1'($urandom);
      #1;
      total++; if (out_if1.valid !== (q1.size() != 0) || occ1 !== 2'(q1.size()) || in_if1.ready !== (q1.size() < 2)) begin
        bad++; $display("FAIL rnd1_ctl[%0d] valid=%b occ=%0d ready=%b exp_occ=%0d", n, out_if1.valid, occ1, in_if1.ready, q1.size());
      end
      if (q1.size() != 0) begin
        total++; if ({out_if1.data, out_if1.reg_wen, out_if1.dmem_alu, out_if1.jr, out_if1.regd} !== q1[0] || wb1 !== exp_wb(q1[0])) begin
          bad++; $display("FAIL rnd1_head[%0d] data=%h regd=%0d wb=%h exp_data=%h exp_regd=%0d exp_wb=%h",
                          n, out_if1.data, out_if1.regd, wb1, q1[0].data, q1[0].regd, exp_wb(q1[0]));
        end
      end else begin
        total++; if (out_if1.reg_wen !== 1'b0) begin bad++; $display("FAIL rnd1_bubble[%0d] wen=%b exp=0", n, out_if1.reg_wen); end
      end
      total++; if (out_if0.valid !== (q0.size() != 0) || occ0 !== 2'(q0.size()) || in_if0.ready !== (out_ready || q0.size() == 0)) begin
        bad++; $display("FAIL rnd0_ctl[%0d] valid=%b occ=%0d ready=%b exp_occ=%0d", n, out_if0.valid, occ0, in_if0.ready, q0.size());
      end
      if (q0.size() != 0) begin
        total++; if ({out_if0.data, out_if0.reg_wen, out_if0.dmem_alu, out_if0.jr, out_if0.regd} !== q0[0] || wb0 !== exp_wb(q0[0])) begin
          bad++; $display("FAIL rnd0_head[%0d] data=%h regd=%0d wb=%h exp_data=%h exp_regd=%0d exp_wb=%h",
                          n, out_if0.data, out_if0.regd, wb0, q0[0].data, q0[0].regd, exp_wb(q0[0]));
        end
      end else begin
        total++; if (out_if0.reg_wen !== 1'b0) begin bad++; $display("FAIL rnd0_bubble[%0d] wen=%b exp=0", n, out_if0.reg_wen); end
      end
      step();
    end
    flush = 1'b0;
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    flush     = 1'b0;
    cur       = '0;
    test_reset();
    test_stream();
    drain();
    test_backpressure();
    drain();
    test_skid0();
    drain();
    test_flush();
    drain();
    test_select();
    drain();
    test_async_reset();
    drain();
    test_random();
    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
